// File: rtl/nv_nvdla_mcif_wr_pipe_chain_pkg.sv
// Shared defaults and occupancy-width helper for the mcif write pipe chain.
package nv_nvdla_mcif_wr_pipe_chain_pkg;

    localparam int WIDTH_DEF = 77;
    localparam int DEPTH_DEF = 2;

    // Each skid stage holds up to two entries, so the counter spans 0..2*depth.
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/nv_nvdla_mcif_wr_pipe_stage.sv
// One registered skid stage: main + skid register, registered ready, flush clears control.
// Latency 1 cycle; output stalls are absorbed by the skid so upstream sees ready one cycle late.
module nv_nvdla_mcif_wr_pipe_stage
    import nv_nvdla_mcif_wr_pipe_chain_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pd
);

    logic             main_vld;
    logic             skid_vld;
    logic             rdy_q;
    logic [WIDTH-1:0] main_dat;
    logic [WIDTH-1:0] skid_dat;
    logic             in_xfer;
    logic             skid_catch;

    assign in_ready   = rdy_q | ~main_vld;
    assign out_valid  = rdy_q ? main_vld : skid_vld;
    assign out_pd     = rdy_q ? main_dat : skid_dat;
    assign in_xfer    = in_valid & in_ready;
    assign skid_catch = main_vld & rdy_q & ~out_ready;

    // rdy_q high implies the skid is empty, so main always vacates while rdy_q is set:
    // either it is taken downstream or it is caught into the skid.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            main_vld <= in_xfer | (main_vld & ~rdy_q);
            skid_vld <= skid_catch | (skid_vld & ~out_ready);
            rdy_q    <= skid_vld ? out_ready : ~skid_catch;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (skid_catch) begin
            skid_dat <= main_dat;
        end
        if (in_xfer) begin
            main_dat <= in_pd;
        end
    end

endmodule

// File: rtl/nv_nvdla_mcif_wr_pipe_chain.sv
// Cascade of DEPTH skid stages with occupancy counter and flush/reset gating.
// Latency DEPTH cycles; holds 2*DEPTH entries before in_ready drops, both ends gated low on flush/reset.
module nv_nvdla_mcif_wr_pipe_chain
    import nv_nvdla_mcif_wr_pipe_chain_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pd,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy,
    output logic             idle
);

    logic             kill;
    logic [DEPTH:0]   c_vld;
    logic [DEPTH:0]   c_rdy;
    logic [WIDTH-1:0] c_pd [DEPTH+1];
    logic             in_xfer;
    logic             out_xfer;

    assign kill         = nvdla_core_rst | flush;
    assign c_vld[0]     = in_valid & ~kill;
    assign c_pd[0]      = in_pd;
    assign in_ready     = c_rdy[0] & ~kill;
    assign out_valid    = c_vld[DEPTH] & ~kill;
    assign out_pd       = c_pd[DEPTH];
    assign c_rdy[DEPTH] = out_ready & ~kill;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            nv_nvdla_mcif_wr_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .nvdla_core_clk (nvdla_core_clk),
                .nvdla_core_rst (nvdla_core_rst),
                .flush          (flush),
                .in_valid       (c_vld[i]),
                .in_ready       (c_rdy[i]),
                .in_pd          (c_pd[i]),
                .out_valid      (c_vld[i+1]),
                .out_ready      (c_rdy[i+1]),
                .out_pd         (c_pd[i+1])
            );
        end
    endgenerate

    // Both ends are gated by kill, so no transfer is ever counted on a flush/reset cycle.
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge nvdla_core_clk) begin
        if (kill) begin
            occupancy <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign idle = (occupancy == '0);

endmodule

// File: tb/tb_nv_nvdla_mcif_wr_pipe_chain.sv
// Scoreboard bench for the write pipe chain at WIDTH=77, DEPTH=3.
module tb_nv_nvdla_mcif_wr_pipe_chain;

    localparam int WIDTH = 77;
    localparam int DEPTH = 3;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_pd = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_pd;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] occupancy;
    logic             idle;

    nv_nvdla_mcif_wr_pipe_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pd          (in_pd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pd         (out_pd),
        .flush          (flush),
        .occupancy      (occupancy),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    bit lat_chk = 1'b0;
    logic [WIDTH-1:0] q[$];
    int               cq[$];
    logic [WIDTH-1:0] nxt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle, compares occupancy against the model count, pops on output transfers.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        int               c;
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        chk("idle", 128'(idle), 128'(q.size() == 0));
        if (rst || flush) begin
            chk("gated_in_ready", 128'(in_ready), 128'(0));
            chk("gated_out_valid", 128'(out_valid), 128'(0));
            q.delete();
            cq.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none (cycle %0d)", out_pd, cyc);
                end else begin
                    e = q.pop_front();
                    c = cq.pop_front();
                    chk("out_pd", 128'(out_pd), 128'(e));
                    if (lat_chk) chk("latency", 128'(cyc - c), 128'(DEPTH));
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_pd);
                cq.push_back(cyc);
                in_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (idle && q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 128'(done), 128'(1));
    endtask

    initial begin
        int a0;
        int o0;
        // reset for two cycles, then check the first cycle after release
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));

        // back-to-back 0x1..0xA with out_ready high: fixed latency of DEPTH, no gaps
        tick();
        o0 = out_cnt;
        lat_chk = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_pd = WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_idle("stream_drain");
        chk("stream_count", 128'(out_cnt - o0), 128'(10));
        lat_chk = 1'b0;

        // fill with out_ready low: exactly 2*DEPTH accepted
        a0 = in_cnt;
        out_ready = 1'b0;
        nxt = WIDTH'(32'h100);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_pd = nxt;
            nxt = nxt + WIDTH'(1);
            tick();
        end
        @(negedge clk);
        chk("full_accepted", 128'(in_cnt - a0), 128'(6));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_occupancy", 128'(occupancy), 128'(6));
        tick();
        o0 = out_cnt;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("full_drain");
        chk("full_drain_count", 128'(out_cnt - o0), 128'(6));

        // flush at occupancy 4
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pd = nxt;
            nxt = nxt + WIDTH'(1);
            tick();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_pre_occupancy", 128'(occupancy), 128'(4));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_occupancy", 128'(occupancy), 128'(0));
        chk("flush_idle", 128'(idle), 128'(1));
        chk("flush_in_ready_after", 128'(in_ready), 128'(1));
        tick();
        o0 = out_cnt;
        lat_chk = 1'b1;
        in_valid = 1'b1;
        in_pd = WIDTH'(77'h155);
        tick();
        in_valid = 1'b0;
        wait_idle("flush_post_drain");
        chk("flush_post_count", 128'(out_cnt - o0), 128'(1));
        lat_chk = 1'b0;

        // random in_valid, out_ready toggling every cycle
        a0 = in_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_pd = {$urandom, $urandom, 13'(nxt)};
            nxt = nxt + WIDTH'(1);
            out_ready = ~out_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle("random_drain");
        chk("random_balance", 128'(out_cnt - o0), 128'(in_cnt - a0));

        // reset at occupancy 5 with both ends active
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pd = nxt;
            nxt = nxt + WIDTH'(1);
            tick();
        end
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_pre_occupancy", 128'(occupancy), 128'(5));
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_occupancy", 128'(occupancy), 128'(0));
        chk("midrst_out_valid_after", 128'(out_valid), 128'(0));
        // any stale payload would surface here as an unexpected output
        for (int i = 0; i < 20; i++) tick();
        o0 = out_cnt;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pd = WIDTH'(32'hA00 + i);
            tick();
        end
        in_valid = 1'b0;
        wait_idle("midrst_drain");
        chk("midrst_post_count", 128'(out_cnt - o0), 128'(3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nv_nvdla_mcif_wr_pipe_chain.md
NV_NVDLA_MCIF_WR_PIPE_CHAIN -- requirements
Module: nv_nvdla_mcif_wr_pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 77: payload width in bits, 1..256.
REQ-002 SHALL have parameter DEPTH, default 2: number of cascaded skid stages, 1..8.
REQ-003 SHALL have parameter CNT_W, default $clog2(2*DEPTH+1): occupancy counter width.
REQ-004 SHALL have port nvdla_core_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nvdla_core_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream payload valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts payload this cycle.
REQ-008 SHALL have port in_pd, input, WIDTH: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: downstream payload valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts payload.
REQ-011 SHALL have port out_pd, output, WIDTH: downstream payload.
REQ-012 SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-013 SHALL have port occupancy, output, CNT_W: number of entries currently held.
REQ-014 SHALL have port idle, output, 1: high exactly when occupancy == 0.

Function
REQ-015 Transfers SHALL occur only on valid&&ready, at each end independently.
REQ-016 Stage k SHALL hold a main register (valid, data), a skid register (valid, data) and a registered ready flag.
REQ-017 Stage input ready SHALL be: registered ready OR NOT main valid.
REQ-018 Stage output SHALL be the main register when registered ready = 1; otherwise it SHALL be the skid register.
REQ-019 Skid catch SHALL occur when main valid && registered ready && NOT downstream ready; the main data is then copied into skid, and skid valid is set.
REQ-020 Skid valid SHALL clear on the first cycle in which downstream ready is high.
REQ-021 Registered ready SHALL update to: skid valid ? downstream ready : NOT skid catch.
REQ-022 Stages SHALL be cascaded in order: stage 0 input is in_*, stage DEPTH-1 output is out_*.
REQ-023 Latency: a payload accepted at cycle t with out_ready held high SHALL appear on out_pd at cycle t+DEPTH.
REQ-024 Throughput SHALL be one payload per cycle sustained, with no bubbles, while out_ready = 1.
REQ-025 Ordering SHALL be strict FIFO; there SHALL be no loss or duplication under any in_valid/out_ready pattern.
REQ-026 Capacity SHALL be 2*DEPTH entries; in_ready SHALL fall no later than the cycle in which occupancy reaches 2*DEPTH.
REQ-027 occupancy SHALL update each cycle as follows: +1 on an in transfer; -1 on an out transfer; unchanged when both or neither occur.
REQ-028 occupancy SHALL NOT wrap; underflow or overflow SHALL be impossible by construction.
REQ-029 Flush cycle: in_ready and out_valid SHALL be forced to 0, and no transfer SHALL count.
REQ-030 On the next cycle after a flush, every valid and skid valid SHALL be 0, every registered ready SHALL be 1, and occupancy SHALL be 0.
REQ-031 flush and reset asserted together SHALL behave as reset.
REQ-032 Payload registers SHALL NOT be reset or cleared; only control state is.

Reset
REQ-033 While nvdla_core_rst = 1, in_ready and out_valid SHALL be 0.
REQ-034 On the first cycle after reset release: out_valid = 0, in_ready = 1, occupancy = 0, idle = 1.
REQ-035 Reset asserted mid-transfer SHALL discard all entries within one cycle, with no partial output.

Structure
REQ-036 The shared package SHALL hold the WIDTH/DEPTH default constants and the CNT_W derivation function.
REQ-037 One sub-module, nv_nvdla_mcif_wr_pipe_stage (a single skid stage per REQ-016..REQ-021, with flush), SHALL be instantiated DEPTH times via generate.
REQ-038 The top level SHALL contain only the cascade, the occupancy counter, and the flush/reset gating.

Verification (WIDTH=77, DEPTH=3)
REQ-039 Reset for 2 cycles, then release -> first cycle after release: in_ready = 1, out_valid = 0, occupancy = 0, idle = 1.
REQ-040 10 payloads 0x1..0xA accepted back-to-back from cycle 0, out_ready = 1 -> out_pd 0x1 at cycle 3 and 0xA at cycle 12, with no gaps.
REQ-041 out_ready = 0, in_valid = 1 continuously -> exactly 6 accepted, in_ready = 0, occupancy = 6; raise out_ready -> 6 outputs in order, occupancy returns to 0.
REQ-042 flush asserted at occupancy = 4 -> that cycle out_valid = 0 and in_ready = 0; next cycle occupancy = 0 and idle = 1; the next accepted payload exits after 3 cycles.
REQ-043 Random in_valid, with out_ready toggling every cycle, for 10k cycles -> scoreboard reports no drop, duplicate or reorder, and occupancy always matches the scoreboard count.
REQ-044 Reset asserted at occupancy = 5 with both ends active -> next cycle occupancy = 0 and out_valid = 0; after release no stale payload ever appears.
